// File: rtl/gpr_cdb_arbiter_pkg.sv
// Shared GPR CDB types: ROB tag width, the broadcast bus struct and the tag comparator.
package gpr_cdb_arbiter_pkg;

  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
    return cdb.valid && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/gpr_cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at N.
module rr_pick #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      // explicit wrap so non-power-of-two N never aliases onto a missing index
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand[IDX_W-1:0]]) begin
        any                     = 1'b1;
        grant[cand[IDX_W-1:0]]  = 1'b1;
        idx                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/gpr_cdb_arbiter.sv
// GPR common-data-bus arbiter: round-robin grant in the request cycle, broadcast of
// the winner's tag and result register one cycle later.
import gpr_cdb_arbiter_pkg::*;

module gpr_cdb_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [ROB_WIDTH-1:0] req_tag [N_REQ],
  input  logic [31:0]          req_result [N_REQ],
  output cdb_t                 gpr_cdb
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IDX_W-1:0]     ptr;
  logic                 g_valid;
  logic [IDX_W-1:0]     g_idx;
  logic [ROB_WIDTH-1:0] g_tag;

  logic [N_REQ-1:0] pick_grant;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] ptr_next;

  rr_pick #(.N(N_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // no grants while in reset; those requests are simply dropped
  assign req_ready = reset ? '0 : pick_grant;

  assign ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      g_valid <= 1'b0;
    end else begin
      g_valid <= pick_any;
      if (pick_any) ptr <= ptr_next;
    end
    g_idx <= pick_idx;
    g_tag <= req_tag[pick_idx];
  end

  // result register of the winner is valid the cycle after grant, hence the registered index
  always_comb begin
    gpr_cdb.valid = g_valid;
    gpr_cdb.tag   = g_valid ? g_tag : 'x;
    gpr_cdb.data  = g_valid ? req_result[g_idx] : 'x;
  end

endmodule

// File: tb/tb_gpr_cdb_arbiter.sv
// Directed self-checking bench for gpr_cdb_arbiter (N_REQ=4) with a tiny mov-station model.
import gpr_cdb_arbiter_pkg::*;

module tb_gpr_cdb_arbiter;

  logic                 clk;
  logic                 reset;
  logic [3:0]           req_valid;
  logic [3:0]           req_ready;
  logic [ROB_WIDTH-1:0] req_tag [4];
  logic [31:0]          req_result [4];
  cdb_t                 gpr_cdb;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_cdb_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_tag    (req_tag),
    .req_result (req_result),
    .gpr_cdb    (gpr_cdb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs are then changed 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  mov_tag [2];
  logic [15:0] mov_imm [2];
  int          head;
  bit          seen0, seen1;
  logic [3:0]  g;

  initial begin
    reset     = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      req_tag[i]    = 6'(i);
      req_result[i] = 32'h0;
    end
    #2;
    chk("reset_ready", req_ready, 4'b0000);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("reset_cdb_valid", gpr_cdb.valid, 1'b0);
    chk("reset_ptr", dut.ptr, 2'd0);

    // single requester
    req_valid  = 4'b0100;
    req_tag[2] = 6'd5;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid     = 4'b0000;
    req_result[2] = 32'hDEADBEEF;
    #1;
    chk("single_cdb_valid", gpr_cdb.valid, 1'b1);
    chk("single_cdb_tag", gpr_cdb.tag, 6'd5);
    chk("single_cdb_data", gpr_cdb.data, 32'hDEADBEEF);
    chk("single_ptr", dut.ptr, 2'd3);

    // idle and hold
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_cdb_valid", gpr_cdb.valid, 1'b0);
      chk("idle_ready", req_ready, 4'b0000);
      chk("idle_ptr", dut.ptr, 2'd3);
    end
    req_valid  = 4'b1000;
    req_tag[3] = 6'd9;
    #1;
    chk("hold_ready", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0000;
    chk("hold_ptr", dut.ptr, 2'd0);
    chk("hold_cdb_tag", gpr_cdb.tag, 6'd9);

    // fairness: all valid for 8 cycles from ptr=0
    for (int i = 0; i < 4; i++) begin
      req_tag[i]    = 6'(10 + i);
      req_result[i] = 32'(100 + i);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_ready", req_ready, 4'b0001 << (k % 4));
      if (k > 0) begin
        chk("fair_cdb_tag", gpr_cdb.tag, 6'(10 + (k - 1) % 4));
        chk("fair_cdb_data", gpr_cdb.data, 32'(100 + (k - 1) % 4));
      end
      tick();
    end
    req_valid = 4'b0000;
    #1;
    chk("fair_last_tag", gpr_cdb.tag, 6'd13);
    chk("fair_ptr", dut.ptr, 2'd0);

    // wrap: reach ptr=3 via a grant to 2, then requests 0 and 1
    req_valid = 4'b0100;
    tick();
    chk("wrap_ptr_pre", dut.ptr, 2'd3);
    req_valid = 4'b0011;
    #1;
    chk("wrap_ready0", req_ready, 4'b0001);
    tick();
    chk("wrap_ptr1", dut.ptr, 2'd1);
    chk("wrap_cdb_tag0", gpr_cdb.tag, 6'd10);
    chk("wrap_ready1", req_ready, 4'b0010);
    tick();
    chk("wrap_ptr2", dut.ptr, 2'd2);
    chk("wrap_cdb_tag1", gpr_cdb.tag, 6'd11);

    // reset mid-stream: grant to 1 (ptr=2 scans 2,3,0,1)
    req_valid = 4'b0010;
    #1;
    chk("rst_mid_ready", req_ready, 4'b0010);
    tick();
    reset     = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("rst_mid_ready_gated", req_ready, 4'b0000);
    chk("rst_mid_cdb_valid", gpr_cdb.valid, 1'b1);
    chk("rst_mid_cdb_tag", gpr_cdb.tag, 6'd11);
    tick();
    reset     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("rst_mid_after_valid", gpr_cdb.valid, 1'b0);
    chk("rst_mid_after_ptr", dut.ptr, 2'd0);

    // integration: requester 1 is a mov station with two queued immediates,
    // requester 0 stays valid throughout
    mov_tag[0] = 6'd20; mov_imm[0] = 16'h8001;
    mov_tag[1] = 6'd21; mov_imm[1] = 16'h007F;
    head = 0; seen0 = 1'b0; seen1 = 1'b0;
    req_tag[0]    = 6'd7;
    req_result[0] = 32'h0000AAAA;
    for (int c = 0; c < 6; c++) begin
      req_valid  = {2'b00, (head < 2), 1'b1};
      req_tag[1] = (head < 2) ? mov_tag[head] : 6'd0;
      #2;
      g = req_ready;
      chk("mov_single_source", ($countones(g) <= 1), 1'b1);
      chk("mov_ready_subset", g & ~req_valid, 4'b0000);
      tick();
      if (g[1]) begin
        req_result[1] = {{16{mov_imm[head][15]}}, mov_imm[head]};
        head++;
      end
      #1;
      if (gpr_cdb.valid && gpr_cdb.tag == 6'd20) begin
        seen0 = 1'b1;
        chk("mov0_data", gpr_cdb.data, 32'hFFFF8001);
      end
      if (gpr_cdb.valid && gpr_cdb.tag == 6'd21) begin
        seen1 = 1'b1;
        chk("mov1_data", gpr_cdb.data, 32'h0000007F);
      end
      if (gpr_cdb.valid && gpr_cdb.tag == 6'd7)
        chk("mov_req0_data", gpr_cdb.data, 32'h0000AAAA);
      if (c == 3) begin
        chk("mov0_seen_by_4", seen0, 1'b1);
        chk("mov1_seen_by_4", seen1, 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
